mem_arbiter: RTL and testbench

Two-master arbiter for the single-port program/data RAM (9-bit word address, 16-bit data, synchronous read). It sits between the RAM and two requesters: port 0 is the CPU (instruction fetch plus LDR/STR), port 1 is the auxiliary master (program loader / debug). It serialises their accesses with round-robin priority, drives the RAM command/address/write-data, and returns read data to the winning requester with a valid pulse.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/rr_pick2.sv | 13 +
 rtl/vDFFenable.sv | 20 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_pkg.sv
// Shared RAM command encodings and arbiter state type.
// The command codes are also used by the CPU, so they must not change.
package mem_pkg;

    localparam logic [1:0] MREAD  = 2'd1;
    localparam logic [1:0] MNONE  = 2'd2;
    localparam logic [1:0] MWRITE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } arb_state_t;

    // 2'b00 and MNONE both mean "no request".
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the two-master RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters and the RAM.
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    r0_cmd;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic [DW-1:0] r0_rdata;
    logic          r0_rvalid;

    logic [1:0]    r1_cmd;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic [DW-1:0] r1_rdata;
    logic          r1_rvalid;

    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_cmd, r0_addr, r0_wdata,
        output r0_gnt, r0_rdata, r0_rvalid,
        input  r1_cmd, r1_addr, r1_wdata,
        output r1_gnt, r1_rdata, r1_rvalid,
        output mem_cmd, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output r0_cmd, r0_addr, r0_wdata,
        input  r0_gnt, r0_rdata, r0_rvalid,
        output r1_cmd, r1_addr, r1_wdata,
        input  r1_gnt, r1_rdata, r1_rvalid,
        input  mem_cmd, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the port that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win,
    output logic       any
);

    assign any = |req;
    assign win = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/vDFFenable.sv
// Register with load enable and synchronous active-high clear.
module vDFFenable #(
    parameter int n = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    // NOTE: clocked state always uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising CPU (port 0) and auxiliary (port 1) accesses
// onto the single-port synchronous-read RAM; every output is registered.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    arb_state_t    state, state_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic [1:0]    req;
    logic          win, any;
    logic [1:0]    cmd_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;
    logic [1:0]    mem_cmd_q, mem_cmd_nxt;
    logic          gnt0_q, gnt1_q, gnt0_nxt, gnt1_nxt;
    logic          rvalid0_q, rvalid1_q, rvalid0_nxt, rvalid1_nxt;
    logic          latch, cap0, cap1;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;

    assign req = {is_req(bus.r1_cmd), is_req(bus.r0_cmd)};

    rr_pick2 u_pick (
        .req (req),
        .last(last_gnt),
        .win (win),
        .any (any)
    );

    assign cmd_sel   = win ? bus.r1_cmd   : bus.r0_cmd;
    assign addr_sel  = win ? bus.r1_addr  : bus.r0_addr;
    assign wdata_sel = win ? bus.r1_wdata : bus.r0_wdata;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        mem_cmd_nxt  = MNONE;
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        rvalid0_nxt  = 1'b0;
        rvalid1_nxt  = 1'b0;
        latch        = 1'b0;
        cap0         = 1'b0;
        cap1         = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    latch        = 1'b1;
                    state_nxt    = ACCESS;
                    last_gnt_nxt = win;
                    mem_cmd_nxt  = cmd_sel;
                    gnt0_nxt     = ~win;
                    gnt1_nxt     = win;
                end
            end
            ACCESS: begin
                state_nxt = (mem_cmd_q == MREAD) ? RDATA : IDLE;
            end
            RDATA: begin
                // last_gnt still names the port whose read is in flight.
                state_nxt   = IDLE;
                cap0        = ~last_gnt;
                cap1        = last_gnt;
                rvalid0_nxt = ~last_gnt;
                rvalid1_nxt = last_gnt;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            mem_cmd_q <= MNONE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_gnt_nxt;
            mem_cmd_q <= mem_cmd_nxt;
            gnt0_q    <= gnt0_nxt;
            gnt1_q    <= gnt1_nxt;
            rvalid0_q <= rvalid0_nxt;
            rvalid1_q <= rvalid1_nxt;
        end
    end

    vDFFenable #(.n(AW)) u_addr (
        .clk(clk), .reset(reset), .en(latch), .d(addr_sel), .q(addr_q)
    );

    vDFFenable #(.n(DW)) u_wdata (
        .clk(clk), .reset(reset), .en(latch), .d(wdata_sel), .q(wdata_q)
    );

    vDFFenable #(.n(DW)) u_rdata0 (
        .clk(clk), .reset(reset), .en(cap0), .d(bus.mem_rdata), .q(rdata0_q)
    );

    vDFFenable #(.n(DW)) u_rdata1 (
        .clk(clk), .reset(reset), .en(cap1), .d(bus.mem_rdata), .q(rdata1_q)
    );

    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.r0_gnt    = gnt0_q;
    assign bus.r1_gnt    = gnt1_q;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant and
// read-return events per cycle; a monitor compares them with the DUT outputs.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        bit            port;
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_item_t;

    typedef struct {
        int            cyc;
        bit            port;
        logic [DW-1:0] data;
    } rv_item_t;

    gnt_item_t     gnt_q[$];
    rv_item_t      rv_q[$];
    logic [DW-1:0] ram     [0:511];
    logic [DW-1:0] ref_mem [0:511];
    int            cyc     = 0;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // RAM environment: synchronous read, data valid the cycle after MREAD.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_cmd == MWRITE) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cmd == MREAD)  bus.mem_rdata     <= ram[bus.mem_addr];
    end

    // Reference model. Inputs seen at the negedge of cycle k are the ones the
    // arbiter samples at the end of cycle k. A request sampled there is granted
    // in cycle k+1; a read returns in cycle k+3 and the arbiter samples again at
    // the end of cycle k+3, a write at the end of cycle k+2.
    bit            last_m = 1'b1;
    int            samp   = 0;
    bit            m_v0, m_v1, m_p;
    logic [1:0]    m_cmd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    always @(negedge clk) begin
        if (reset) begin
            while (gnt_q.size() > 0 && gnt_q[$].cyc > cyc) void'(gnt_q.pop_back());
            while (rv_q.size() > 0 && rv_q[$].cyc > cyc) void'(rv_q.pop_back());
            last_m = 1'b1;
            samp   = cyc + 1;
        end else if (cyc == samp) begin
            m_v0 = (bus.r0_cmd == MREAD) || (bus.r0_cmd == MWRITE);
            m_v1 = (bus.r1_cmd == MREAD) || (bus.r1_cmd == MWRITE);
            if (m_v0 || m_v1) begin
                m_p     = (m_v0 && m_v1) ? !last_m : m_v1;
                last_m  = m_p;
                m_cmd   = m_p ? bus.r1_cmd   : bus.r0_cmd;
                m_addr  = m_p ? bus.r1_addr  : bus.r0_addr;
                m_wdata = m_p ? bus.r1_wdata : bus.r0_wdata;
                gnt_q.push_back('{cyc + 1, m_p, m_cmd, m_addr, m_wdata});
                if (m_cmd == MREAD) begin
                    rv_q.push_back('{cyc + 3, m_p, ref_mem[m_addr]});
                    samp = cyc + 3;
                end else begin
                    ref_mem[m_addr] = m_wdata;
                    samp = cyc + 2;
                end
            end else begin
                samp = cyc + 1;
            end
        end
    end

    // Monitor: pops the expected event for this cycle, otherwise expects quiet outputs.
    bit            rst_prev = 1'b0;
    bit            started  = 1'b0;
    logic [DW-1:0] shadow0, shadow1;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    gnt_item_t     g;
    rv_item_t      r;

    always @(negedge clk) begin
        if (rst_prev) begin
            started   = 1'b1;
            shadow0   = '0;
            shadow1   = '0;
            exp_addr  = '0;
            exp_wdata = '0;
            check("rst_gnt",       32'({bus.r1_gnt, bus.r0_gnt}), 32'd0);
            check("rst_rvalid",    32'({bus.r1_rvalid, bus.r0_rvalid}), 32'd0);
            check("rst_mem_cmd",   32'(bus.mem_cmd), 32'(MNONE));
            check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
            check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
            check("rst_r0_rdata",  32'(bus.r0_rdata), 32'd0);
            check("rst_r1_rdata",  32'(bus.r1_rdata), 32'd0);
        end else if (started) begin
            check("gnt_exclusive",    32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
            check("rvalid_exclusive", 32'(bus.r0_rvalid & bus.r1_rvalid), 32'd0);
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                g = gnt_q.pop_front();
                check("gnt_port",  32'({bus.r1_gnt, bus.r0_gnt}), g.port ? 32'd2 : 32'd1);
                check("mem_cmd",   32'(bus.mem_cmd), 32'(g.cmd));
                check("mem_addr",  32'(bus.mem_addr), 32'(g.addr));
                check("mem_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
                exp_addr  = g.addr;
                exp_wdata = g.wdata;
            end else begin
                check("gnt_quiet",      32'({bus.r1_gnt, bus.r0_gnt}), 32'd0);
                check("mem_cmd_quiet",  32'(bus.mem_cmd), 32'(MNONE));
                check("mem_addr_hold",  32'(bus.mem_addr), 32'(exp_addr));
                check("mem_wdata_hold", 32'(bus.mem_wdata), 32'(exp_wdata));
            end
            if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
                r = rv_q.pop_front();
                check("rvalid_port", 32'({bus.r1_rvalid, bus.r0_rvalid}), r.port ? 32'd2 : 32'd1);
                if (r.port) shadow1 = r.data;
                else        shadow0 = r.data;
            end else begin
                check("rvalid_quiet", 32'({bus.r1_rvalid, bus.r0_rvalid}), 32'd0);
            end
            check("r0_rdata", 32'(bus.r0_rdata), 32'(shadow0));
            check("r1_rdata", 32'(bus.r1_rdata), 32'(shadow1));
        end
        rst_prev = reset;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input bit p, input logic [1:0] c, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (p) begin
            bus.r1_cmd = c; bus.r1_addr = a; bus.r1_wdata = d;
        end else begin
            bus.r0_cmd = c; bus.r0_addr = a; bus.r0_wdata = d;
        end
    endtask

    // Returns in the grant cycle; a timeout counts as a failed comparison.
    task automatic wait_gnt(input bit p);
        logic got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            got = p ? bus.r1_gnt : bus.r0_gnt;
        end
        check(p ? "gnt_wait_p1" : "gnt_wait_p0", 32'(got), 32'd1);
    endtask

    task automatic rand_driver(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            int gap = int'($urandom_range(0, 3));
            for (int k = 0; k < gap; k++) begin
                set_req(p, ($urandom_range(0, 1) != 0) ? MNONE : 2'b00,
                        AW'($urandom_range(0, 15)), DW'($urandom));
                idle(1);
            end
            set_req(p, ($urandom_range(0, 1) != 0) ? MREAD : MWRITE,
                    AW'($urandom_range(0, 15)), DW'($urandom));
            wait_gnt(p);
        end
        set_req(p, MNONE, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        set_req(0, MNONE, '0, '0);
        set_req(1, MNONE, '0, '0);
        bus.mem_rdata <= '0;
        for (int i = 0; i < 512; i++) begin
            v = (i == 5) ? 16'hBEEF : DW'($urandom);
            ram[i]     <= v;
            ref_mem[i]  = v;
        end
        reset = 1'b1;
        idle(3);
        reset = 1'b0;

        // Port 0 read of address 5.
        set_req(0, MREAD, 9'h005, 16'h0000);
        wait_gnt(0);
        set_req(0, MNONE, '0, '0);
        idle(4);

        // Port 1 write, then read back through port 0.
        set_req(1, MWRITE, 9'h010, 16'h1234);
        wait_gnt(1);
        set_req(1, MNONE, '0, '0);
        idle(2);
        set_req(0, MREAD, 9'h010, 16'h0000);
        wait_gnt(0);
        set_req(0, MNONE, '0, '0);
        idle(4);

        // Both ports reading continuously right after a reset.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        set_req(0, MREAD, 9'h005, 16'h1111);
        set_req(1, MREAD, 9'h010, 16'h2222);
        idle(13);
        set_req(0, MNONE, '0, '0);
        set_req(1, MNONE, '0, '0);
        idle(4);

        // Port 1 read arrives while port 0's write is on the bus.
        set_req(0, MWRITE, 9'h020, 16'hA5A5);
        wait_gnt(0);
        set_req(0, MNONE, '0, '0);
        set_req(1, MREAD, 9'h020, 16'h0000);
        wait_gnt(1);
        set_req(1, MNONE, '0, '0);
        idle(4);

        // Reset during RDATA, then a tie that port 0 must win.
        set_req(0, MREAD, 9'h005, 16'h0000);
        wait_gnt(0);
        set_req(0, MNONE, '0, '0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        set_req(0, MWRITE, 9'h030, 16'h0F0F);
        set_req(1, MWRITE, 9'h031, 16'hF0F0);
        wait_gnt(0);
        set_req(0, MNONE, '0, '0);
        wait_gnt(1);
        set_req(1, MNONE, '0, '0);
        idle(3);

        // Encoding 2'b00 is not a request.
        set_req(0, 2'b00, 9'h005, 16'h0000);
        idle(5);
        set_req(0, MNONE, '0, '0);
        idle(2);

        // Randomized traffic from both ports.
        fork
            rand_driver(0, 40);
            rand_driver(1, 40);
        join
        idle(6);

        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        check("rv_q_drained",  32'(rv_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
